// File: rtl/hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_ctrl : front-end load/hold/flush sequencing for the five-stage core
// Revision    : 1.0
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_mul_start,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_wipe,
  output logic             idex_power,
  output logic             idex_wipe,
  output logic             mul_done,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MULW = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  state_t     state_q;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  assign state = state_q;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Outputs decode combinationally so they settle before the negedge sample.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_wipe  = 1'b0;
    idex_power = 1'b0;
    idex_wipe  = 1'b0;
    mul_done   = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    state_nxt  = state_q;
    cnt_nxt    = cnt;
    case (state_q)
      IDLE: begin
        ifid_wipe = 1'b1;
        idex_wipe = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_power = 1'b1;
        if (ex_branch_taken) begin
          ifid_wipe = 1'b1;
          idex_wipe = 1'b1;
          flush_inc = 1'b1;
        end else if (ex_mul_start) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_power = 1'b0;
          cnt_nxt    = MUL_INIT;
          state_nxt  = MULW;
        end else if (load_use) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_wipe = 1'b1;
          stall_inc = 1'b1;
        end else if (id_jump) begin
          ifid_wipe = 1'b1;
          flush_inc = 1'b1;
        end else if (halt_req) begin
          state_nxt = HALT;
        end
      end
      MULW: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          mul_done  = 1'b1;
          state_nxt = RUN;
        end
      end
      HALT: begin
        idex_power = 1'b1;
        idex_wipe  = 1'b1;
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt       <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_nxt;
      cnt     <= cnt_nxt;
      // Counters stick at all-ones rather than wrapping.
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_hazard_ctrl : vector table, corner sequences and random model compare
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, start, halt_req, id_uses_rt, id_jump;
  logic ex_mem_read, ex_branch_taken, ex_mul_start;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic pc_en, ifid_en, ifid_wipe, idex_power, idex_wipe, mul_done;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_mul_start(ex_mul_start), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_wipe(ifid_wipe), .idex_power(idex_power), .idex_wipe(idex_wipe),
    .mul_done(mul_done), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic rst, st, hlt, jmp, mr, urt, br, mul;
    logic [4:0] rs, rt, ert;
  } stim_t;

  typedef struct packed {
    logic pc, ifen, ifw, pw, iw, md;
    logic [1:0] st;
    logic [CNT_W-1:0] stall, flush;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: mode, freeze cycles elapsed, event totals.
  int m_mode, m_elapsed, m_stall, m_flush;

  function automatic stim_t mk_s(input logic r, s, h, j, mr, u, b, m,
                                 input int rs, rt, ert);
    stim_t x;
    x = '{rst:r, st:s, hlt:h, jmp:j, mr:mr, urt:u, br:b, mul:m,
          rs:5'(rs), rt:5'(rt), ert:5'(ert)};
    return x;
  endfunction

  function automatic exp_t mk_e(input logic pc, ifen, ifw, pw, iw, md,
                                input int st, stall, flush);
    exp_t x;
    x = '{pc:pc, ifen:ifen, ifw:ifw, pw:pw, iw:iw, md:md,
          st:2'(st), stall:CNT_W'(stall), flush:CNT_W'(flush)};
    return x;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst; start = s.st; halt_req = s.hlt; id_jump = s.jmp;
    ex_mem_read = s.mr; id_uses_rt = s.urt; ex_branch_taken = s.br;
    ex_mul_start = s.mul; id_rs = s.rs; id_rt = s.rt; ex_rt = s.ert;
  endtask

  function automatic exp_t actual();
    return '{pc:pc_en, ifen:ifid_en, ifw:ifid_wipe, pw:idex_power, iw:idex_wipe,
             md:mul_done, st:state, stall:stall_cnt, flush:flush_cnt};
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("pc=%b ifen=%b ifw=%b pw=%b iw=%b md=%b st=%0d stall=%0d flush=%0d",
                     x.pc, x.ifen, x.ifw, x.pw, x.iw, x.md, x.st, x.stall, x.flush);
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual {%s} required {%s}", name, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, got, exp);
    end
  endtask

  // One clock: drive, compare at negedge, advance past posedge.
  task automatic cycle(input stim_t s, input exp_t e, input string name);
    apply(s);
    @(negedge clk);
    check(name, actual(), e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input stim_t s);
    apply(s);
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_load_use(input stim_t s);
    return s.mr && (s.ert != 0) && ((s.ert == s.rs) || (s.urt && (s.ert == s.rt)));
  endfunction

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    e = mk_e(0, 0, 0, 0, 0, 0, m_mode, m_stall, m_flush);
    case (m_mode)
      0: begin e.ifw = 1; e.iw = 1; end
      1: begin
        e.pc = 1; e.ifen = 1; e.pw = 1;
        if (s.br) begin e.ifw = 1; e.iw = 1; end
        else if (s.mul) begin e.pc = 0; e.ifen = 0; e.pw = 0; end
        else if (is_load_use(s)) begin e.pc = 0; e.ifen = 0; e.iw = 1; end
        else if (s.jmp) e.ifw = 1;
      end
      2: e.md = (m_elapsed == MUL_LAT);
      default: begin e.pw = 1; e.iw = 1; end
    endcase
    return e;
  endfunction

  task automatic model_step(input stim_t s);
    if (s.rst) begin
      m_mode = 0; m_elapsed = 0; m_stall = 0; m_flush = 0;
    end else begin
      case (m_mode)
        0: if (s.st) m_mode = 1;
        1: begin
          if (s.br) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
          else if (s.mul) begin m_mode = 2; m_elapsed = 2; end
          else if (is_load_use(s)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
          else if (s.jmp) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
          else if (s.hlt) m_mode = 3;
        end
        2: if (m_elapsed == MUL_LAT) m_mode = 1; else m_elapsed++;
        default: if (s.st) m_mode = 1;
      endcase
    end
  endtask

  vec_t tbl[21];
  stim_t z, rs1;

  initial begin
    z   = mk_s(0,0,0,0,0,0,0,0, 0,0,0);
    rs1 = mk_s(1,0,0,0,0,0,0,0, 0,0,0);
    //              r s h j mr u b m  rs rt ert        pc if ifw pw iw md st stl fl
    tbl[0]  = '{mk_s(1,0,0,0,0,0,0,0, 0,0,0), mk_e(0,0,1,0,1,0, 0,0,0)};
    tbl[1]  = '{mk_s(0,1,0,0,0,0,0,0, 0,0,0), mk_e(0,0,1,0,1,0, 0,0,0)};
    tbl[2]  = '{mk_s(0,0,0,0,0,0,0,0, 0,0,0), mk_e(1,1,0,1,0,0, 1,0,0)};
    tbl[3]  = '{mk_s(0,0,0,0,1,0,0,0, 5,0,5), mk_e(0,0,0,1,1,0, 1,0,0)};
    tbl[4]  = '{mk_s(0,0,0,0,0,0,0,0, 0,0,0), mk_e(1,1,0,1,0,0, 1,1,0)};
    tbl[5]  = '{mk_s(0,0,0,0,1,0,0,0, 0,0,0), mk_e(1,1,0,1,0,0, 1,1,0)};
    tbl[6]  = '{mk_s(0,0,0,0,1,1,0,0, 3,7,7), mk_e(0,0,0,1,1,0, 1,1,0)};
    tbl[7]  = '{mk_s(0,0,0,0,1,0,0,0, 3,7,7), mk_e(1,1,0,1,0,0, 1,2,0)};
    tbl[8]  = '{mk_s(0,0,0,0,1,0,1,0, 5,0,5), mk_e(1,1,1,1,1,0, 1,2,0)};
    tbl[9]  = '{mk_s(0,0,0,1,0,0,0,0, 0,0,0), mk_e(1,1,1,1,0,0, 1,2,1)};
    tbl[10] = '{mk_s(0,0,0,1,1,0,0,0, 9,0,9), mk_e(0,0,0,1,1,0, 1,2,2)};
    tbl[11] = '{mk_s(0,0,1,0,0,0,0,1, 0,0,0), mk_e(0,0,0,0,0,0, 1,3,2)};
    tbl[12] = '{mk_s(0,0,0,0,0,0,1,0, 0,0,0), mk_e(0,0,0,0,0,0, 2,3,2)};
    tbl[13] = '{mk_s(0,0,0,0,0,0,0,0, 0,0,0), mk_e(0,0,0,0,0,0, 2,3,2)};
    tbl[14] = '{mk_s(0,1,0,0,0,0,0,0, 0,0,0), mk_e(0,0,0,0,0,1, 2,3,2)};
    tbl[15] = '{mk_s(0,0,1,0,0,0,0,0, 0,0,0), mk_e(1,1,0,1,0,0, 1,3,2)};
    tbl[16] = '{mk_s(0,0,0,0,0,0,0,0, 0,0,0), mk_e(0,0,0,1,1,0, 3,3,2)};
    tbl[17] = '{mk_s(0,1,0,0,0,0,0,0, 0,0,0), mk_e(0,0,0,1,1,0, 3,3,2)};
    tbl[18] = '{mk_s(0,0,1,1,0,0,0,0, 0,0,0), mk_e(1,1,1,1,0,0, 1,3,2)};
    tbl[19] = '{mk_s(0,0,1,0,0,0,0,0, 0,0,0), mk_e(1,1,0,1,0,0, 1,3,3)};
    tbl[20] = '{mk_s(0,0,0,0,0,0,0,0, 0,0,0), mk_e(0,0,0,1,1,0, 3,3,3)};

    apply(rs1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 21; i++)
      cycle(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));

    // Reset during a multi-cycle freeze aborts it.
    idle_cycle(rs1);
    idle_cycle(mk_s(0,1,0,0,0,0,0,0, 0,0,0));
    idle_cycle(mk_s(0,0,0,0,0,0,0,1, 0,0,0));
    apply(rs1);
    @(negedge clk);
    check_int("mulw_before_reset", state, 2);
    @(posedge clk); #1;
    apply(z);
    @(negedge clk);
    check_int("reset_in_mulw", state, 0);
    check_int("reset_in_mulw_pc_en", pc_en, 0);
    @(posedge clk); #1;

    // Halt request dropped while a branch competes never halts.
    idle_cycle(mk_s(0,1,0,0,0,0,0,0, 0,0,0));
    idle_cycle(mk_s(0,0,1,0,0,0,1,0, 0,0,0));
    idle_cycle(z);
    check_int("halt_cancel", state, 1);

    // A held load-use match saturates the stall counter.
    for (int i = 0; i < 20; i++)
      idle_cycle(mk_s(0,0,0,0,1,0,0,0, 4,0,4));
    apply(z);
    @(negedge clk);
    check_int("stall_saturate", stall_cnt, CMAX);
    check_int("flush_after_saturate", flush_cnt, 1);
    @(posedge clk); #1;

    // Random traffic against the model, starting from a known reset.
    idle_cycle(rs1);
    model_step(rs1);
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      exp_t e;
      s = mk_s($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      e = model_out(s);
      cycle(s, e, $sformatf("rand%0d", i));
      model_step(s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
